// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding and default address width / reset PC.
package cpu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam logic [WIDTH_DEF-1:0] RESET_PC_DEF = '0;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, shares the memory port with execute-stage stores
// (stores win), hands instructions to decode over valid/ready. FETCH_ASSERT_EN adds assertions.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_we,
  output logic [2*WIDTH-1:0] mem_wdata,
  input  logic [2*WIDTH-1:0] mem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [2*WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0]   ir_pc,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  input  logic               st_req,
  input  logic [WIDTH-1:0]   st_addr,
  input  logic [2*WIDTH-1:0] st_data,
  input  logic               halt_req,
  output logic               halted
);

  fetch_state_t       state, state_d;
  logic [WIDTH-1:0]   pc_p0, pc_d;
  logic               vld_p1, vld_d;
  logic [2*WIDTH-1:0] ir_data_p1, ir_data_d;
  logic [WIDTH-1:0]   ir_pc_p1, ir_pc_d;

  // Stage p0: shared memory port, store has priority over the fetch address
  always_comb begin
    mem_addr  = st_req ? st_addr : pc_p0;
    mem_we    = st_req && rst_n;
    mem_wdata = st_req ? st_data : '0;
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc_p0;
    vld_d     = vld_p1;
    ir_data_d = ir_data_p1;
    ir_pc_d   = ir_pc_p1;
    case (state)
      S_RUN: begin
        if (halt_req) begin
          vld_d   = 1'b0;
          state_d = S_HALT;
          if (br_valid) pc_d = br_target;
        end else if (br_valid) begin
          pc_d  = br_target;
          vld_d = 1'b0;
        end else if (st_req) begin
          // The store steals this fetch slot; a consumed instruction is not replaced.
          if (vld_p1 && ir_ready) vld_d = 1'b0;
        end else if (!vld_p1 || ir_ready) begin
          ir_data_d = mem_rdata;
          ir_pc_d   = pc_p0;
          vld_d     = 1'b1;
          pc_d      = pc_p0 + 1'b1;
        end
      end
      S_HALT: begin
        vld_d = 1'b0;
        if (br_valid) begin
          pc_d    = br_target;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stage p1: instruction register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RUN;
      pc_p0      <= RESET_PC;
      vld_p1     <= 1'b0;
      ir_data_p1 <= '0;
      ir_pc_p1   <= '0;
    end else begin
      state      <= state_d;
      pc_p0      <= pc_d;
      vld_p1     <= vld_d;
      ir_data_p1 <= ir_data_d;
      ir_pc_p1   <= ir_pc_d;
    end
  end

  assign ir_valid = vld_p1;
  assign ir_data  = ir_data_p1;
  assign ir_pc    = ir_pc_p1;
  assign halted   = (state == S_HALT);

`ifdef FETCH_ASSERT_EN
  a_ir_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ir_valid && !ir_ready && !br_valid && !halt_req |=> $stable(ir_valid) && $stable(ir_data));
  a_we_addr: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> !$isunknown(mem_addr));
  a_halt_empty: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> !ir_valid);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences and randomized traffic vs. a reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        st_req;
  logic [7:0]  st_addr;
  logic [15:0] st_data;
  logic        halt_req;
  logic        halted;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .br_valid(br_valid), .br_target(br_target),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, write on posedge.
  logic [15:0] mem [256];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(16'h1000 + i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Reference model state.
  logic [15:0] mmem [256];
  logic        m_h, m_v;
  logic [7:0]  m_pc, m_ipc;
  logic [15:0] m_d;
  logic        we_seen;

  typedef struct {
    logic rdy, br; logic [7:0] tgt; logic st; logic [7:0] sa; logic [15:0] sd; logic halt;
    logic e_we, e_v; logic [7:0] e_pc; logic [15:0] e_d; logic e_h;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rdy, logic br, logic [7:0] tgt, logic st, logic [7:0] sa,
                              logic [15:0] sd, logic halt, logic e_we, logic e_v,
                              logic [7:0] e_pc, logic [15:0] e_d, logic e_h);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.st = st; v.sa = sa; v.sd = sd; v.halt = halt;
    v.e_we = e_we; v.e_v = e_v; v.e_pc = e_pc; v.e_d = e_d; v.e_h = e_h;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic rdy, input logic br, input logic [7:0] tgt,
                            input logic st, input logic [7:0] sa, input logic [15:0] sd,
                            input logic halt);
    if (!r) begin
      m_h = 1'b0; m_pc = 8'h00; m_v = 1'b0; m_d = 16'h0; m_ipc = 8'h00;
    end else begin
      if (!m_h) begin
        if (halt) begin
          m_v = 1'b0; m_h = 1'b1;
          if (br) m_pc = tgt;
        end else if (br) begin
          m_pc = tgt; m_v = 1'b0;
        end else if (st) begin
          if (m_v && rdy) m_v = 1'b0;
        end else if (!m_v || rdy) begin
          m_d = mmem[m_pc]; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 8'd1;
        end
      end else if (br) begin
        m_pc = tgt; m_h = 1'b0;
      end
      if (st) mmem[sa] = sd;
    end
  endtask

  // One clock: apply inputs, check the port mux before the edge, check registers after it.
  task automatic drive(input logic r, input logic rdy, input logic br, input logic [7:0] tgt,
                       input logic st, input logic [7:0] sa, input logic [15:0] sd,
                       input logic halt);
    rst_n = r; ir_ready = rdy; br_valid = br; br_target = tgt;
    st_req = st; st_addr = sa; st_data = sd; halt_req = halt;
    @(negedge clk);
    we_seen = mem_we;
    chk("mem_addr", 32'(mem_addr), 32'(st ? sa : m_pc));
    chk("mem_we", 32'(mem_we), 32'(st && r));
    chk("mem_wdata", 32'(mem_wdata), 32'(st ? sd : 16'h0));
    model_step(r, rdy, br, tgt, st, sa, sd, halt);
    @(posedge clk);
    #1;
    chk("ir_valid", 32'(ir_valid), 32'(m_v));
    chk("halted", 32'(halted), 32'(m_h));
    chk("ir_pc", 32'(ir_pc), 32'(m_ipc));
    chk("ir_data", 32'(ir_data), 32'(m_d));
  endtask

  initial begin
    rst_n = 1'b0; ir_ready = 1'b0; br_valid = 1'b0; br_target = 8'h00;
    st_req = 1'b1; st_addr = 8'h77; st_data = 16'hDEAD; halt_req = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < 256; i++) mmem[i] = 16'(16'h1000 + i);
    @(posedge clk);
    @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ir_pc", 32'(ir_pc), 32'h0);
    chk("rst_ir_data", 32'(ir_data), 32'h0);
    st_req = 1'b0;
    m_h = 1'b0; m_pc = 8'h00; m_v = 1'b0; m_d = 16'h0; m_ipc = 8'h00;
    #1;
    chk("rst_pc_addr", 32'(mem_addr), 32'h0);

    // Directed vectors: rdy, br, tgt, st, sa, sd, halt | we, valid, ir_pc, ir_data, halted
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'(i), 16'(16'h1000 + i), 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h05, 16'h1005, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h06, 16'h1006, 0));
    tbl.push_back(mk(1, 0, 0,     1, 8'h10, 16'hBEEF, 0, 1, 0, 8'h06, 16'h1006, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h07, 16'h1007, 0));
    tbl.push_back(mk(1, 1, 8'h10, 0, 0,     0,        0, 0, 0, 8'h07, 16'h1007, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h10, 16'hBEEF, 0));
    tbl.push_back(mk(1, 1, 8'h40, 0, 0,     0,        0, 0, 0, 8'h10, 16'hBEEF, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h40, 16'h1040, 0));
    tbl.push_back(mk(1, 1, 8'hFF, 0, 0,     0,        0, 0, 0, 8'h40, 16'h1040, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'hFF, 16'h10FF, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h00, 16'h1000, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        1, 0, 0, 8'h00, 16'h1000, 1));
    tbl.push_back(mk(1, 0, 0,     1, 8'h30, 16'h1234, 1, 1, 0, 8'h00, 16'h1000, 1));
    tbl.push_back(mk(1, 1, 8'h30, 0, 0,     0,        0, 0, 0, 8'h00, 16'h1000, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0, 1, 8'h30, 16'h1234, 0));

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].rdy, tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].sa, tbl[i].sd, tbl[i].halt);
      chk($sformatf("vec%0d_we", i), 32'(we_seen), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d_valid", i), 32'(ir_valid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].e_h));
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d_pc", i), 32'(ir_pc), 32'(tbl[i].e_pc));
        chk($sformatf("vec%0d_data", i), 32'(ir_data), 32'(tbl[i].e_d));
      end
    end

    // Reset mid-stream with a pending store: store dropped, state back to reset values.
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 16'hDEAD, 1'b0);
    chk("midrst_we", 32'(we_seen), 32'h0);
    chk("midrst_valid", 32'(ir_valid), 32'h0);
    chk("midrst_pc", 32'(ir_pc), 32'h0);
    chk("midrst_data", 32'(ir_data), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0, 1'b0);
    chk("postrst_pc", 32'(ir_pc), 32'h0);
    chk("postrst_data", 32'(ir_data), 32'h1000);
    drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0, 1'b0);
    chk("dropped_store", 32'(ir_data), 32'h1055);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 10,
            8'($urandom),
            $urandom_range(0, 99) < 15,
            8'($urandom),
            16'($urandom),
            $urandom_range(0, 99) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
